// File: rtl/pulp_clock_divider.sv
// Programmable glitch-free integer clock divider.
// The divided clock is a flop output; ratio changes and enable/disable only
// take effect on period boundaries, so clk_o never produces a runt pulse.
module pulp_clock_divider #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 cfg_valid_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    output logic                 cfg_ready_o,
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 clk_o,
    output logic                 running_o
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
    logic [DIV_WIDTH-1:0] div_reg, div_next;
    logic [DIV_WIDTH-1:0] pend_div_reg, pend_div_next;
    logic                 pend_valid_reg, pend_valid_next;
    logic                 clk_reg, clk_next;

    logic [DIV_WIDTH-1:0] half_div;
    logic [DIV_WIDTH-1:0] cnt_inc;
    logic [DIV_WIDTH-1:0] cfg_div_eff;
    logic                 boundary;
    logic                 accept;
    logic                 apply_pend;

    // Values below 2 cannot form a clock period, so they are clamped on entry
    // and only the effective ratio is ever stored.
    assign cfg_div_eff = (cfg_div_i < MIN_DIV) ? MIN_DIV : cfg_div_i;
    assign half_div    = div_reg >> 1;
    assign cnt_inc     = cnt_reg + 1'b1;
    assign boundary    = (state_reg == ST_RUN) && (cnt_reg == div_reg - 1'b1);
    assign accept      = cfg_valid_i && !pend_valid_reg;
    // In IDLE the pending value is applied right away unless we are starting
    // this very cycle; then the first period keeps the old ratio and the new
    // one lands on the next boundary.
    assign apply_pend  = pend_valid_reg &&
                         (boundary || ((state_reg == ST_IDLE) && !en_i));

    // Next-state logic for run state, period counter, divided clock and config.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        clk_next        = clk_reg;
        div_next        = div_reg;
        pend_div_next   = pend_div_reg;
        pend_valid_next = pend_valid_reg;

        unique case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                clk_next = 1'b0;
                if (en_i) begin
                    state_next = ST_RUN;
                    clk_next   = 1'b1;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    cnt_next = '0;
                    if (en_i) begin
                        clk_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        clk_next   = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_inc;
                    clk_next = (cnt_inc < half_div);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                clk_next   = 1'b0;
            end
        endcase

        // accept and apply_pend are mutually exclusive: one needs the slot
        // empty, the other needs it full.
        if (apply_pend) begin
            div_next        = pend_div_reg;
            pend_valid_next = 1'b0;
        end
        if (accept) begin
            pend_div_next   = cfg_div_eff;
            pend_valid_next = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            clk_reg        <= 1'b0;
            div_reg        <= DEF_DIV;
            pend_div_reg   <= DEF_DIV;
            pend_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            clk_reg        <= clk_next;
            div_reg        <= div_next;
            pend_div_reg   <= pend_div_next;
            pend_valid_reg <= pend_valid_next;
        end
    end

    assign clk_o       = clk_reg;
    assign div_o       = div_reg;
    assign cfg_ready_o = !pend_valid_reg;
    assign running_o   = (state_reg == ST_RUN);

endmodule

// File: tb/tb_pulp_clock_divider.sv
// Self-checking bench for pulp_clock_divider: a cycle-level behavioural model
// checked every cycle, plus directed sequences with literal expected waveforms.
module tb_pulp_clock_divider;

    localparam int W   = 8;
    localparam int DEF = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready;
    logic [W-1:0] div_out;
    logic         clk_out;
    logic         running;

    int checks = 0;
    int errors = 0;

    pulp_clock_divider #(
        .DIV_WIDTH  (W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .cfg_valid_i(cfg_valid),
        .cfg_div_i  (cfg_div),
        .cfg_ready_o(cfg_ready),
        .div_o      (div_out),
        .clk_o      (clk_out),
        .running_o  (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the absolute cycle index at which the current period began; the
    // expected clock is derived from how far into the period we are.
    int  cyc = 0;
    int  m_start = 0;
    int  m_n = DEF;
    int  m_pend = DEF;
    bit  m_run = 0;
    bit  m_pv = 0;
    bit  m_ok = 0;

    always @(posedge clk) begin
        int  c;
        bit  bnd, acc, app;
        c = cyc;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_run = 0;
            m_n   = DEF;
            m_pv  = 0;
            m_ok  = 1;
        end else begin
            bnd = m_run && ((c - m_start) == m_n - 1);
            acc = cfg_valid && !m_pv;
            app = m_pv && (bnd || (!m_run && !en));
            if (m_run) begin
                if (bnd) begin
                    if (en) m_start = c + 1;
                    else    m_run = 0;
                end
            end else if (en) begin
                m_run   = 1;
                m_start = c + 1;
            end
            if (app) begin
                m_n  = m_pend;
                m_pv = 0;
            end
            if (acc) begin
                m_pv   = 1;
                m_pend = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (m_ok) begin
            int exp_clk;
            exp_clk = (m_run && ((cyc - m_start) < (m_n / 2))) ? 1 : 0;
            chk("model_clk_o", int'(clk_out), exp_clk);
            chk("model_running_o", int'(running), int'(m_run));
            chk("model_div_o", int'(div_out), m_n);
            chk("model_cfg_ready_o", int'(cfg_ready), int'(!m_pv));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input string name, input logic [15:0] pat, input int len);
        for (int i = 0; i < len; i++) begin
            tick();
            chk(name, int'(clk_out), int'(pat[len-1-i]));
        end
    endtask

    task automatic wait_stopped();
        int n;
        n = 0;
        while (running && n < 40) begin
            tick();
            n++;
        end
        chk("wait_stop_timeout", int'(running), 0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cfg_ready && n < 40) begin
            tick();
            n++;
        end
        chk("wait_ready_timeout", int'(cfg_ready), 1);
    endtask

    task automatic load_idle(input int d);
        cfg_valid = 1'b1;
        cfg_div   = W'(d);
        tick();
        cfg_valid = 1'b0;
        chk("idle_load_ready_low", int'(cfg_ready), 0);
        tick();
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_clk_o", int'(clk_out), 0);
        chk("rst_running_o", int'(running), 0);
        chk("rst_div_o", int'(div_out), 2);
        chk("rst_cfg_ready_o", int'(cfg_ready), 1);
        rst_n = 1'b1;
        tick();

        // Default N=2
        $display("seq: default divide-by-2");
        en = 1'b1;
        check_seq("n2_pattern", 16'b1010, 4);
        chk("n2_div_o", int'(div_out), 2);
        chk("n2_ready", int'(cfg_ready), 1);

        // Load 5 in IDLE, then run
        $display("seq: load 5 in idle");
        en = 1'b0;
        wait_stopped();
        load_idle(5);
        chk("idle_load5_div_o", int'(div_out), 5);
        en = 1'b1;
        check_seq("n5_pattern", 16'b1100011000, 10);

        // N=4, load 7 at cnt=1
        $display("seq: N=4 load 7 mid-period");
        en = 1'b0;
        wait_stopped();
        load_idle(4);
        en = 1'b1;
        tick();
        chk("n4_c0", int'(clk_out), 1);
        tick();
        chk("n4_c1", int'(clk_out), 1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd7;
        tick();
        cfg_valid = 1'b0;
        chk("n4_c2", int'(clk_out), 0);
        chk("n4_ready_low_after_accept", int'(cfg_ready), 0);
        chk("n4_div_held", int'(div_out), 4);
        tick();
        chk("n4_c3", int'(clk_out), 0);
        chk("n4_ready_low_boundary", int'(cfg_ready), 0);
        tick();
        chk("n7_first", int'(clk_out), 1);
        chk("n7_div_o", int'(div_out), 7);
        chk("n7_ready_back", int'(cfg_ready), 1);
        check_seq("n7_pattern", 16'b11000011, 8);

        // Clamp: load 0 then 1
        $display("seq: load 0 and 1 clamp to 2");
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        tick();
        cfg_valid = 1'b0;
        wait_ready();
        chk("load0_div_o", int'(div_out), 2);
        chk("load0_clk_first", int'(clk_out), 1);
        check_seq("load0_pattern", 16'b010, 3);
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        tick();
        cfg_valid = 1'b0;
        wait_ready();
        chk("load1_div_o", int'(div_out), 2);
        check_seq("load1_pattern", 16'b0101, 4);

        // N=6, drop en at cnt=1
        $display("seq: N=6 stop mid-period");
        en = 1'b0;
        wait_stopped();
        load_idle(6);
        en = 1'b1;
        tick();
        chk("n6_c0", int'(clk_out), 1);
        tick();
        chk("n6_c1", int'(clk_out), 1);
        en = 1'b0;
        check_seq("n6_finish", 16'b10000, 5);
        chk("n6_stopped", int'(running), 0);
        tick();
        chk("n6_idle_clk", int'(clk_out), 0);
        en = 1'b1;
        tick();
        chk("n6_restart_clk", int'(clk_out), 1);
        chk("n6_restart_running", int'(running), 1);

        // Reset mid-period with pending value
        $display("seq: reset with pending");
        cfg_valid = 1'b1;
        cfg_div   = 8'd9;
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("pend_ready_low", int'(cfg_ready), 0);
        rst_n = 1'b0;
        en    = 1'b0;
        tick();
        chk("rst2_clk_o", int'(clk_out), 0);
        chk("rst2_div_o", int'(div_out), 2);
        chk("rst2_ready", int'(cfg_ready), 1);
        chk("rst2_running", int'(running), 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst2_pend_discarded", int'(div_out), 2);

        // Deterministic mixed traffic; the model checks every cycle.
        $display("seq: mixed traffic");
        for (int i = 0; i < 300; i++) begin
            en        = ((i % 37) < 30);
            cfg_valid = ((i % 11) == 0) || ((i % 37) == 30);
            cfg_div   = W'(i % 9);
            tick();
        end
        cfg_valid = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
